// File: rtl/pim_pkg.sv
// Shared PIM array constants and the bitline-reader FSM encoding.
// Bus chunk width, row width and chunk count are fixed here for the whole array slice.
package pim_pkg;

    localparam int PIM_DATA_W  = 16;
    localparam int PIM_WORD_W  = 256;
    localparam int PIM_N_CHUNK = PIM_WORD_W / PIM_DATA_W;
    localparam int PIM_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SEND   = 2'd3
    } bl_state_t;

endpackage

// File: rtl/bl_reader.sv
// Reads one PIM array row and streams it out MSB-first as WORD_W/DATA_W chunks.
// Latency: strobe 1 cycle after start, first chunk 1 cycle after array valid.
// Backpressure: valid/ready; chunk, index and last hold while i_ready is low.
module bl_reader
    import pim_pkg::*;
#(
    parameter int DATA_W      = PIM_DATA_W,
    parameter int WORD_W      = PIM_WORD_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 i_read_start,
    output logic                 o_array_rd_en,
    input  logic                 i_array_valid,
    input  logic [WORD_W-1:0]    i_array_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_W-1:0]    o_data,
    output logic [PIM_CNT_W-1:0] o_counter,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int N_CHUNK = WORD_W / DATA_W;
    localparam logic [PIM_CNT_W-1:0] LAST_IDX = PIM_CNT_W'(N_CHUNK - 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    // Timeout is measured from the strobe cycle, so the final WAIT cycle sees TIMEOUT_CYC-2.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

    bl_state_t            state_q, state_d;
    logic [WORD_W-1:0]    buf_q, buf_d;
    logic [PIM_CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 rd_en_q, rd_en_d;
    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [WORD_W-1:0]    shifted;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_read_start) begin
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                state_d = ST_WAIT;
                tmr_d   = '0;
            end
            ST_WAIT: begin
                // Capture beats a timeout landing in the same cycle.
                if (i_array_valid) begin
                    buf_d   = i_array_data;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end else if (tmr_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_SEND: begin
                if (valid_q && i_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + PIM_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        shifted = buf_d << (DATA_W * cnt_d);
        rd_en_d = (state_d == ST_STROBE);
        valid_d = (state_d == ST_SEND);
        last_d  = valid_d && (cnt_d == LAST_IDX);
        busy_d  = (state_d != ST_IDLE);
        data_d  = valid_d ? shifted[WORD_W-1 -: DATA_W] : '0;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_array_rd_en = rd_en_q;
    assign o_valid       = valid_q;
    assign o_data        = data_q;
    assign o_counter     = cnt_q;
    assign o_last        = last_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_bl_reader.sv
// Directed bench for bl_reader: streaming, backpressure, timeout, reset abort, back-to-back rows.
module tb_bl_reader;
    import pim_pkg::*;

    logic                  CLK = 1'b0;
    logic                  RSTN;
    logic                  i_read_start;
    logic                  o_array_rd_en;
    logic                  i_array_valid;
    logic [PIM_WORD_W-1:0] i_array_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [PIM_DATA_W-1:0] o_data;
    logic [PIM_CNT_W-1:0]  o_counter;
    logic                  o_last;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PIM_WORD_W-1:0] row_inc;
    logic [PIM_WORD_W-1:0] row_ones;

    bl_reader #(
        .DATA_W     (PIM_DATA_W),
        .WORD_W     (PIM_WORD_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .i_read_start (i_read_start),
        .o_array_rd_en(o_array_rd_en),
        .i_array_valid(i_array_valid),
        .i_array_data (i_array_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_counter    (o_counter),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [15:0] chunk_of(input logic [PIM_WORD_W-1:0] row, input int k);
        logic [PIM_WORD_W-1:0] t;
        t = row << (16 * k);
        return t[PIM_WORD_W-1 -: 16];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_rd_en"},   64'(o_array_rd_en), 64'd0);
        check({tag, "_valid"},   64'(o_valid),       64'd0);
        check({tag, "_data"},    64'(o_data),        64'd0);
        check({tag, "_counter"}, 64'(o_counter),     64'd0);
        check({tag, "_last"},    64'(o_last),        64'd0);
        check({tag, "_busy"},    64'(o_busy),        64'd0);
        check({tag, "_done"},    64'(o_done),        64'd0);
        check({tag, "_err"},     64'(o_err),         64'd0);
    endtask

    // Start a read, answer the strobe after lat WAIT cycles, leave the FSM in SEND.
    task automatic issue_read(input logic [PIM_WORD_W-1:0] row, input int lat);
        i_read_start = 1'b1;
        step();
        i_read_start = 1'b0;
        check("rd_en_pulse", 64'(o_array_rd_en), 64'd1);
        check("busy_strobe", 64'(o_busy), 64'd1);
        step();
        check("rd_en_one_cycle", 64'(o_array_rd_en), 64'd0);
        repeat (lat) step();
        i_array_valid = 1'b1;
        i_array_data  = row;
        step();
        i_array_valid = 1'b0;
        i_array_data  = ~row;
        check("valid_rise", 64'(o_valid), 64'd1);
        check("counter_start", 64'(o_counter), 64'd0);
    endtask

    // Drain with i_ready high; stray array valid during SEND must not disturb the buffer.
    task automatic drain_fast(input logic [PIM_WORD_W-1:0] row);
        i_ready       = 1'b1;
        i_array_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("fast_data",    64'(o_data),    64'(chunk_of(row, k)));
            check("fast_counter", 64'(o_counter), 64'(k));
            check("fast_last",    64'(o_last),    64'(k == 15));
            check("fast_valid",   64'(o_valid),   64'd1);
            step();
        end
        i_ready       = 1'b0;
        i_array_valid = 1'b0;
        check("done_pulse",   64'(o_done),    64'd1);
        check("done_valid",   64'(o_valid),   64'd0);
        check("done_busy",    64'(o_busy),    64'd0);
        check("done_counter", 64'(o_counter), 64'd0);
        step();
        check("done_one_cycle", 64'(o_done), 64'd0);
    endtask

    task automatic drain_toggle(input logic [PIM_WORD_W-1:0] row);
        int   idx;
        logic rdy;
        idx = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (!o_valid) break;
            check("tog_data",    64'(o_data),    64'(chunk_of(row, idx)));
            check("tog_counter", 64'(o_counter), 64'(idx));
            check("tog_last",    64'(o_last),    64'(idx == 15));
            rdy     = (cyc % 2 == 0);
            i_ready = rdy;
            step();
            if (rdy) idx++;
        end
        i_ready = 1'b0;
        check("tog_xfer_count", 64'(idx), 64'd16);
        check("tog_done", 64'(o_done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   rd_cnt;
        logic saw_valid;

        row_inc = '0;
        for (int k = 0; k < 16; k++) row_inc = (row_inc << 16) | PIM_WORD_W'(k + 1);
        row_ones = '1;

        RSTN          = 1'b0;
        i_read_start  = 1'b0;
        i_array_valid = 1'b0;
        i_array_data  = '0;
        i_ready       = 1'b0;
        repeat (2) @(negedge CLK);
        check_idle("reset");
        RSTN = 1'b1;
        step();

        // Straight streaming with i_ready held high.
        issue_read(row_inc, 2);
        drain_fast(row_inc);

        // Backpressure: i_ready alternates 1,0,...
        issue_read(row_inc, 0);
        drain_toggle(row_inc);
        step();

        // Timeout; array valid outside WAIT is ignored.
        i_array_valid = 1'b1;
        i_array_data  = row_inc;
        step();
        check("idle_valid_ignored", 64'(o_busy), 64'd0);
        i_read_start = 1'b1;
        step();
        i_read_start = 1'b0;
        check("tmo_rd_en", 64'(o_array_rd_en), 64'd1);
        step();
        i_array_valid = 1'b0;
        n         = 1;
        saw_valid = o_valid;
        while (!o_err && n < 40) begin
            step();
            n++;
            saw_valid = saw_valid | o_valid;
        end
        check("tmo_cycles", 64'(n), 64'd16);
        check("tmo_no_valid", 64'(saw_valid), 64'd0);
        check("tmo_busy", 64'(o_busy), 64'd0);
        step();
        check("tmo_err_one_cycle", 64'(o_err), 64'd0);

        // Array valid in the timeout-expiry cycle: capture wins.
        i_read_start = 1'b1;
        step();
        i_read_start = 1'b0;
        check("coin_rd_en", 64'(o_array_rd_en), 64'd1);
        repeat (15) step();
        i_array_valid = 1'b1;
        i_array_data  = row_inc;
        step();
        i_array_valid = 1'b0;
        check("coin_no_err", 64'(o_err), 64'd0);
        check("coin_valid", 64'(o_valid), 64'd1);
        drain_fast(row_inc);

        // Asynchronous reset during chunk 7, then a fresh read.
        issue_read(row_inc, 1);
        i_ready = 1'b1;
        n = 0;
        while (o_counter != 4'd7 && n < 20) begin
            step();
            n++;
        end
        i_ready = 1'b0;
        check("abort_chunk7", 64'(o_data), 64'(chunk_of(row_inc, 7)));
        #2 RSTN = 1'b0;
        #1 check_idle("async_rst");
        @(negedge CLK);
        RSTN = 1'b1;
        step();
        step();
        check("no_resume_valid", 64'(o_valid), 64'd0);
        check("no_resume_busy", 64'(o_busy), 64'd0);
        issue_read(row_ones, 3);
        drain_fast(row_ones);

        // i_read_start held high: one strobe per row, restart right after o_done.
        i_ready      = 1'b1;
        i_read_start = 1'b1;
        rd_cnt       = 0;
        step();
        check("b2b_rd_en0", 64'(o_array_rd_en), 64'd1);
        if (o_array_rd_en) rd_cnt++;
        step();
        i_array_valid = 1'b1;
        i_array_data  = row_inc;
        step();
        i_array_valid = 1'b0;
        n = 0;
        while (!o_done && n < 40) begin
            if (o_array_rd_en) rd_cnt++;
            step();
            n++;
        end
        check("b2b_one_strobe", 64'(rd_cnt), 64'd1);
        check("b2b_done", 64'(o_done), 64'd1);
        step();
        check("b2b_restart", 64'(o_array_rd_en), 64'd1);
        i_read_start = 1'b0;
        step();
        i_array_valid = 1'b1;
        i_array_data  = row_ones;
        step();
        i_array_valid = 1'b0;
        check("b2b_row2_data", 64'(o_data), 64'hffff);
        n = 0;
        while (!o_done && n < 40) begin
            step();
            n++;
        end
        check("b2b_row2_done", 64'(o_done), 64'd1);
        i_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
